// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache responder.
//   - state_e           : refill FSM states
//   - *_DEF, OFF_W, IDX_W, TAG_W : default geometry and the field widths it implies
//   - addr_off/idx/tag  : address field extraction. The field widths are arguments,
//                         so the same helpers serve any LINES/LINE_WORDS choice.
//                         Results are right-aligned in 32 bits; callers size-cast.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int LINES_DEF      = 64;
  localparam int LINE_WORDS_DEF = 4;
  localparam int OFF_W          = $clog2(LINE_WORDS_DEF);
  localparam int IDX_W          = $clog2(LINES_DEF);
  localparam int TAG_W          = 30 - OFF_W - IDX_W;

  function automatic logic [31:0] addr_off(input logic [31:0] a, input int ow);
    return (a >> 2) & ((32'd1 << ow) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int ow, input int iw);
    return (a >> (ow + 2)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int ow, input int iw);
    return a >> (ow + iw + 2);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line-refill sequencer for icache_responder.
// Owns the FSM state, the latched miss-line address, the request handshake
// and the beat counter. The cache arrays live in the parent. This block only
// tells the parent when and where to write.
//   clock, reset          : clock, synchronous active-high reset
//   miss_i                : lookup missed (only acted on in IDLE)
//   miss_line_i           : line-aligned address of the current fetch
//   mem_req_ready_i       : memory accepts the request
//   mem_resp_valid_i      : one refill beat is on the response bus
//   state_o               : current state
//   mem_req_valid_o/addr_o: line-fill request
//   beat_we_o, word_sel_o : write the response word into word word_sel_o of the fill line
//   line_done_o           : last beat. The parent sets the valid bit and writes the tag.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          miss_i,
  input  logic [31:0]                   miss_line_i,
  input  logic                          mem_req_ready_i,
  input  logic                          mem_resp_valid_i,
  output state_e                        state_o,
  output logic                          mem_req_valid_o,
  output logic [31:0]                   mem_req_addr_o,
  output logic                          beat_we_o,
  output logic [$clog2(LINE_WORDS)-1:0] word_sel_o,
  output logic                          line_done_o
);

  localparam int CW = $clog2(LINE_WORDS);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    mem_req_valid_o = 1'b0;
    beat_we_o       = 1'b0;
    line_done_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_i) begin
          state_d = REQ;
          addr_d  = miss_line_i;
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        if (mem_resp_valid_i) begin
          beat_we_o = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(LINE_WORDS - 1)) begin
            line_done_o = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state_o        = state_q;
  assign mem_req_addr_o = addr_q;
  assign word_sel_o     = cnt_q;

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache on the fetch port.
// A hit returns the word combinationally with no stall. A miss stalls fetch
// and refills the whole line from memory, one beat per word.
// Optional macro ICACHE_PERF_EN adds two saturating 32-bit counters:
// io_perf_hits counts IDLE hit cycles, and io_perf_misses counts IDLE->REQ transitions.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   io_cache_addr / io_cache_din  : fetch byte address; write data (unused)
//   io_cache_dout / io_stall      : instruction word; 1 = word not available
//   io_mem_req_valid/ready/addr   : line-fill request (line-aligned address)
//   io_mem_resp_valid/data        : refill beats in ascending word order
//   io_perf_hits/misses           : only with ICACHE_PERF_EN
module icache_responder
  import icache_pkg::*;
#(
  parameter int LINES      = LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_cache_addr,
  input  logic [31:0] io_cache_din,
  output logic [31:0] io_cache_dout,
  output logic        io_stall,
  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_req_addr,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] io_perf_hits,
  output logic [31:0] io_perf_misses
`endif
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  // Valid bits are reset. Tags and data are not: a line is only read once its valid bit is set.
  logic [LINES-1:0]                       valid_q;
  logic [LINES-1:0][TW-1:0]               tag_q;
  logic [LINES-1:0][LINE_WORDS-1:0][31:0] data_q;

  logic [OW-1:0] off;
  logic [IW-1:0] idx, fill_idx;
  logic [TW-1:0] tag, fill_tag;
  logic          hit, idle, miss_start;

  state_e        state;
  logic          beat_we, line_done;
  logic [OW-1:0] word_sel;

  logic unused_din;
  assign unused_din = ^io_cache_din;

  assign off = OW'(addr_off(io_cache_addr, OW));
  assign idx = IW'(addr_idx(io_cache_addr, OW, IW));
  assign tag = TW'(addr_tag(io_cache_addr, OW, IW));

  // All writes go to the latched line, so a redirect mid-refill cannot move the fill.
  assign fill_idx = IW'(addr_idx(io_mem_req_addr, OW, IW));
  assign fill_tag = TW'(addr_tag(io_mem_req_addr, OW, IW));

  assign idle       = (state == IDLE);
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign miss_start = idle && !hit;
  assign io_stall   = !idle || !hit;
  assign io_cache_dout = data_q[idx][off];

  icache_refill_fsm #(.LINE_WORDS(LINE_WORDS)) u_fsm (
    .clock            (clock),
    .reset            (reset),
    .miss_i           (!hit),
    .miss_line_i      ({io_cache_addr[31:OW+2], {(OW+2){1'b0}}}),
    .mem_req_ready_i  (io_mem_req_ready),
    .mem_resp_valid_i (io_mem_resp_valid),
    .state_o          (state),
    .mem_req_valid_o  (io_mem_req_valid),
    .mem_req_addr_o   (io_mem_req_addr),
    .beat_we_o        (beat_we),
    .word_sel_o       (word_sel),
    .line_done_o      (line_done)
  );

  // The victim line is invalidated on the miss cycle. This keeps it from reading
  // as a hit while its words are being overwritten.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (miss_start) begin
      valid_q[idx] <= 1'b0;
    end else if (line_done) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (beat_we)   data_q[fill_idx][word_sel] <= io_mem_resp_data;
    if (line_done) tag_q[fill_idx]            <= fill_tag;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (idle && hit && (hits_q != '1))  hits_d   = hits_q + 32'd1;
    if (miss_start && (misses_q != '1)) misses_d = misses_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign io_perf_hits   = hits_q;
  assign io_perf_misses = misses_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] io_cache_addr, io_cache_din, io_cache_dout;
  logic        io_stall, io_mem_req_valid, io_mem_req_ready;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] io_perf_hits, io_perf_misses;
`endif

  always #5 clock = ~clock;

  icache_responder dut (
    .clock             (clock),
    .reset             (reset),
    .io_cache_addr     (io_cache_addr),
    .io_cache_din      (io_cache_din),
    .io_cache_dout     (io_cache_dout),
    .io_stall          (io_stall),
    .io_mem_req_valid  (io_mem_req_valid),
    .io_mem_req_ready  (io_mem_req_ready),
    .io_mem_req_addr   (io_mem_req_addr),
    .io_mem_resp_valid (io_mem_resp_valid),
    .io_mem_resp_data  (io_mem_resp_data)
`ifdef ICACHE_PERF_EN
    ,
    .io_perf_hits      (io_perf_hits),
    .io_perf_misses    (io_perf_misses)
`endif
  );

  int vec = 0;
  int errs = 0;

  // Scoreboard queues: words the monitor should see, and line requests memory should see.
  logic [31:0] exp_dat[$];
  logic [31:0] exp_req[$];

  // Reference cache contents: 64 lines of 16 bytes; index = (a/16)%64, tag = a/1024.
  bit          mv[64];
  logic [31:0] mt[64];
  int          fills_done = 0;
  bit          rst_next = 0;
  bit          mon_en = 0;
  int          hits_m = 0;
  int          misses_m = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a ^ 32'h5EED0000) * 32'h00010003 + 32'h00001234;
  endfunction

  function automatic int lidx(input logic [31:0] a);
    return int'((a >> 4) % 64);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mv[lidx(a)] && (mt[lidx(a)] == (a >> 10));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    vec++;
    errs++;
    $display("FAIL %s: timed out", name);
  endtask

  // Present one fetch. Hold the address until the word is delivered, then release after the next edge.
  task automatic fetch(input logic [31:0] a);
    bit hit;
    int n;
    hit = model_hit(a);
    if (!hit) exp_req.push_back(a & ~32'hF);
    exp_dat.push_back(memw(a & ~32'h3));
    io_cache_addr = a;
    @(negedge clock);
    check("first-cycle stall", {31'd0, io_stall}, {31'd0, !hit});
    n = 0;
    while (io_stall && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) timeout("fetch stall");
    @(posedge clock); #1;
  endtask

  // Miss on a, then redirect to b while the refill is in flight.
  task automatic redirect(input logic [31:0] a, input logic [31:0] b);
    int f0, n;
    if (model_hit(a)) begin
      fetch(a);
      return;
    end
    exp_req.push_back(a & ~32'hF);
    io_cache_addr = a;
    f0 = fills_done;
    @(posedge clock);
    @(posedge clock); #1;
    io_cache_addr = b;
    n = 0;
    while (fills_done == f0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) timeout("redirect fill");
    if (!model_hit(b)) exp_req.push_back(b & ~32'hF);
    exp_dat.push_back(memw(b & ~32'h3));
    n = 0;
    @(negedge clock);
    while (io_stall && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) timeout("redirect stall");
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return ({30'd0, 2'($urandom_range(0, 3))} << 10) | ({30'd0, 2'($urandom_range(0, 3))} << 4) |
           ({30'd0, 2'($urandom_range(0, 3))} << 2) | {30'd0, 2'($urandom_range(0, 3))};
  endfunction

  // Monitor: every non-stalled cycle delivers exactly one expected word.
  task automatic monitor();
    logic [31:0] w;
    forever begin
      @(negedge clock);
      if (mon_en && !reset && !io_stall) begin
        if (exp_dat.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL dout: unexpected word %h delivered", io_cache_dout);
        end else begin
          w = exp_dat.pop_front();
          check("dout", io_cache_dout, w);
        end
        hits_m++;
      end
    end
  endtask

  // Memory model: random request backpressure, random beat gaps, stray beats,
  // and an optional reset after two beats.
  task automatic memory();
    logic [31:0] line;
    bit abort;
    forever begin
      @(negedge clock);
      if (io_mem_req_valid === 1'b1) begin
        if (exp_req.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL req: unexpected request %h", io_mem_req_addr);
          line = io_mem_req_addr;
        end else begin
          line = exp_req.pop_front();
          check("req_addr", io_mem_req_addr, line);
        end
        misses_m++;
        abort = 0;
        io_mem_req_ready = 1'b0;
        repeat ($urandom_range(0, 5)) begin
          @(negedge clock);
          check("req_valid hold", {31'd0, io_mem_req_valid}, 32'd1);
          check("req_addr hold", io_mem_req_addr, line);
        end
        io_mem_req_ready = 1'b1;
        @(negedge clock);
        io_mem_req_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
          repeat ($urandom_range(0, 2)) @(negedge clock);
          io_mem_resp_valid = 1'b1;
          io_mem_resp_data  = memw(line + 32'(4 * w));
          @(negedge clock);
          io_mem_resp_valid = 1'b0;
          io_mem_resp_data  = $urandom;
          if (rst_next && w == 1) begin
            reset    = 1'b1;
            rst_next = 0;
            abort    = 1;
            for (int i = 0; i < 64; i++) mv[i] = 0;
            hits_m   = 0;
            misses_m = 0;
            exp_req.push_back(line);
            @(negedge clock);
            reset = 1'b0;
          end
        end
        if (!abort) begin
          mv[lidx(line)] = 1;
          mt[lidx(line)] = line >> 10;
          fills_done++;
          if ($urandom_range(0, 1) == 1) begin
            io_mem_resp_valid = 1'b1;
            io_mem_resp_data  = $urandom;
            @(negedge clock);
            io_mem_resp_valid = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mv[i] = 0;
      mt[i] = '0;
    end
    reset             = 1'b1;
    io_cache_addr     = 32'h00001000;
    io_cache_din      = 32'hDEADBEEF;
    io_mem_req_ready  = 1'b0;
    io_mem_resp_valid = 1'b0;
    io_mem_resp_data  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset stall", {31'd0, io_stall}, 32'd1);
    check("reset req_valid", {31'd0, io_mem_req_valid}, 32'd0);
    check("reset req_addr", io_mem_req_addr, 32'd0);
`ifdef ICACHE_PERF_EN
    check("reset perf_hits", io_perf_hits, 32'd0);
    check("reset perf_misses", io_perf_misses, 32'd0);
`endif
    reset  = 1'b0;
    mon_en = 1;
    fork
      monitor();
      memory();
    join_none
    @(posedge clock); #1;

    fetch(32'h00001000);
    fetch(32'h0000100C);
    fetch(32'h00001004);
    fetch(32'h00001008);
`ifdef ICACHE_PERF_EN
    check("perf_hits s1", io_perf_hits, 32'd4);
    check("perf_misses s1", io_perf_misses, 32'd1);
`endif
    fetch(32'h00001400);
    fetch(32'h00001000);
    fetch(32'h00001400);
    redirect(32'h00001000, 32'h00002000);
    rst_next = 1;
    fetch(32'h00005010);
    fetch(32'h00005014);

    for (int n = 0; n < 150; n++) begin
      if (n % 10 == 5) redirect(rnd_addr(), rnd_addr());
      else             fetch(rnd_addr());
    end

`ifdef ICACHE_PERF_EN
    check("perf_hits", io_perf_hits, 32'(hits_m));
    check("perf_misses", io_perf_misses, 32'(misses_m));
`endif
    mon_en = 0;
    check("leftover words", 32'(exp_dat.size()), 32'd0);
    check("leftover reqs", 32'(exp_req.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
